// File: rtl/mem_request_ctrl_pkg.sv
// Shared definitions for the load/store memory request controller.
package mem_request_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam int MEM_LAT_DEFAULT = 11;
  localparam int TIMEOUT_DEFAULT = 32;
  localparam int WAIT_CNT_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Debug view of the controller: FSM state, wait counter, and a flag that is
  // high while a response is later than the nominal memory latency.
  typedef struct packed {
    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    past_nominal;
  } dbg_t;

  function automatic logic is_load_op(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LW);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_request_ctrl_if.sv
// Bundle of the LSQ request, data-memory and completion channels.
//
// Handshakes: a transfer on req_* or cmp_* happens on a rising clock edge
// where valid and ready are both high. The producer keeps valid and its
// payload stable until that edge; ready may change freely and never depends
// on valid from the same channel in a way that forms a loop.
interface mem_request_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic [31:0] req_addr;
  logic [5:0]  req_reg;
  logic [3:0]  req_optype;
  logic [31:0] req_data;

  logic [31:0] mem_inst_pc;
  logic [31:0] mem_address;
  logic [31:0] mem_dataSw;
  logic [5:0]  mem_reg;
  logic [3:0]  mem_optype;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        mem_cache_miss;
  logic [31:0] mem_ld_data;
  logic        mem_ld_valid;
  logic        mem_st_done;

  logic        cmp_valid;
  logic        cmp_ready;
  logic [31:0] cmp_pc;
  logic [5:0]  cmp_reg;
  logic [31:0] cmp_data;
  logic        cmp_is_store;
  logic        cmp_err;

  // Controller side.
  modport master (
    input  req_valid, req_pc, req_addr, req_reg, req_optype, req_data,
    output req_ready,
    output mem_inst_pc, mem_address, mem_dataSw, mem_reg, mem_optype,
    output mem_read_en, mem_write_en, mem_cache_miss,
    input  mem_ld_data, mem_ld_valid, mem_st_done,
    output cmp_valid, cmp_pc, cmp_reg, cmp_data, cmp_is_store, cmp_err,
    input  cmp_ready
  );

  // LSQ / memory / writeback side.
  modport slave (
    output req_valid, req_pc, req_addr, req_reg, req_optype, req_data,
    input  req_ready,
    input  mem_inst_pc, mem_address, mem_dataSw, mem_reg, mem_optype,
    input  mem_read_en, mem_write_en, mem_cache_miss,
    output mem_ld_data, mem_ld_valid, mem_st_done,
    input  cmp_valid, cmp_pc, cmp_reg, cmp_data, cmp_is_store, cmp_err,
    output cmp_ready
  );

endinterface

// File: rtl/mem_request_ctrl_wait_timer.sv
// Saturating wait counter with an expiry flag at TIMEOUT-1.
module mem_wait_timer
  import mem_request_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_enable,
  output logic [WAIT_CNT_W-1:0] o_count,
  output logic                  o_expired
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT   = WAIT_CNT_W'(TIMEOUT - 1);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

  logic [WAIT_CNT_W-1:0] r_count;

  // Count enabled cycles, stopping at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_count   = r_count;
  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_request_ctrl.sv
// Single-outstanding load/store initiator: accepts one op from the LSQ,
// issues it to data memory, waits for the response (or times out) and
// presents a completion record to writeback.
module mem_request_ctrl
  import mem_request_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  mem_request_ctrl_if.master  io_bus,
  output dbg_t                o_dbg
);

  localparam logic [WAIT_CNT_W-1:0] LAT_CNT = WAIT_CNT_W'(MEM_LAT);

  state_t                r_state;
  state_t                w_next_state;
  logic [31:0]           r_pc;
  logic [31:0]           r_addr;
  logic [31:0]           r_data;
  logic [31:0]           r_ld_data;
  logic [5:0]            r_reg;
  logic [3:0]            r_op;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_resp;
  logic                  w_timeout;
  logic                  w_req_supported;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_timer_clear;
  logic                  w_timer_en;
  logic                  w_expired;
  logic [WAIT_CNT_W-1:0] w_wait_cnt;

  assign w_req_supported = is_load_op(io_bus.req_optype) | is_store_op(io_bus.req_optype);
  assign w_is_load       = is_load_op(r_op);
  assign w_is_store      = is_store_op(r_op);

  // The counter sits at zero through ISSUE and advances once per ISSUE/WAIT
  // cycle, so it equals the number of cycles elapsed since ISSUE.
  assign w_timer_clear = (r_state == ST_IDLE);
  assign w_timer_en    = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_count   (w_wait_cnt),
    .o_expired (w_expired)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection plus request, strobe and completion outputs.
  always_comb begin
    w_next_state          = r_state;
    w_accept              = 1'b0;
    w_resp                = 1'b0;
    w_timeout             = 1'b0;
    io_bus.req_ready      = 1'b0;
    io_bus.mem_optype     = OP_NOP;
    io_bus.mem_read_en    = 1'b0;
    io_bus.mem_write_en   = 1'b0;
    io_bus.cmp_valid      = 1'b0;
    io_bus.cmp_pc         = '0;
    io_bus.cmp_reg        = '0;
    io_bus.cmp_data       = '0;
    io_bus.cmp_is_store   = 1'b0;
    io_bus.cmp_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        io_bus.req_ready = 1'b1;
        if (io_bus.req_valid) begin
          w_accept     = 1'b1;
          // Unsupported ops never touch memory; they complete with an error.
          w_next_state = w_req_supported ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        io_bus.mem_optype   = r_op;
        io_bus.mem_write_en = w_is_store;
        io_bus.mem_read_en  = w_is_load;
        w_next_state        = ST_WAIT;
      end
      ST_WAIT: begin
        io_bus.mem_read_en = w_is_load;
        // Only the pulse matching the op kind counts; a response on the
        // expiry cycle takes priority over the timeout.
        w_resp = (w_is_load & io_bus.mem_ld_valid) | (w_is_store & io_bus.mem_st_done);
        if (w_resp) begin
          w_next_state = ST_DONE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        io_bus.cmp_valid    = 1'b1;
        io_bus.cmp_pc       = r_pc;
        io_bus.cmp_reg      = r_reg;
        io_bus.cmp_data     = r_ld_data;
        io_bus.cmp_is_store = w_is_store;
        io_bus.cmp_err      = r_err;
        if (io_bus.cmp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the request on accept and the load data / error on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_reg     <= '0;
      r_op      <= OP_NOP;
      r_err     <= 1'b0;
      r_ld_data <= '0;
    end else begin
      if (w_accept) begin
        r_pc      <= io_bus.req_pc;
        r_addr    <= io_bus.req_addr;
        r_data    <= io_bus.req_data;
        r_reg     <= io_bus.req_reg;
        r_op      <= io_bus.req_optype;
        r_err     <= ~w_req_supported;
        r_ld_data <= '0;
      end
      if (w_resp && w_is_load) begin
        r_ld_data <= io_bus.mem_ld_data;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_bus.mem_inst_pc    = r_pc;
  assign io_bus.mem_address    = r_addr;
  assign io_bus.mem_dataSw     = r_data;
  assign io_bus.mem_reg        = r_reg;
  assign io_bus.mem_cache_miss = io_bus.mem_read_en;

  assign o_dbg.state        = r_state;
  assign o_dbg.wait_cnt     = w_wait_cnt;
  assign o_dbg.past_nominal = (r_state == ST_WAIT) && (w_wait_cnt > LAT_CNT);

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Self-checking bench for mem_request_ctrl: directed cases plus randomized
// ops checked against a transaction-level completion model.
module tb_mem_request_ctrl;
  import mem_request_ctrl_pkg::*;

  localparam int MEM_LAT = 11;
  localparam int TIMEOUT = 32;
  localparam int REC_W   = 72;  // {pc[32], reg[6], data[32], is_store, err}

  logic clk = 1'b0;
  logic rst;
  dbg_t dbg;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [REC_W-1:0] exp_q[$];

  mem_request_ctrl_if bus();

  mem_request_ctrl #(
    .MEM_LAT (MEM_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus),
    .o_dbg  (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid    = 1'b0;
    bus.req_pc       = '0;
    bus.req_addr     = '0;
    bus.req_reg      = '0;
    bus.req_optype   = '0;
    bus.req_data     = '0;
    bus.mem_ld_data  = '0;
    bus.mem_ld_valid = 1'b0;
    bus.mem_st_done  = 1'b0;
    bus.cmp_ready    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, bus.req_ready, 1);
    check_val({tag, "_mem_optype"}, bus.mem_optype, 0);
    check_val({tag, "_mem_read_en"}, bus.mem_read_en, 0);
    check_val({tag, "_mem_write_en"}, bus.mem_write_en, 0);
    check_val({tag, "_mem_cache_miss"}, bus.mem_cache_miss, 0);
    check_val({tag, "_mem_fields"}, {bus.mem_inst_pc, bus.mem_address, bus.mem_dataSw, bus.mem_reg}, 0);
    check_val({tag, "_cmp_valid"}, bus.cmp_valid, 0);
    check_val({tag, "_cmp_fields"},
              {bus.cmp_pc, bus.cmp_reg, bus.cmp_data, bus.cmp_is_store, bus.cmp_err}, 0);
  endtask

  // ---------------- driver + model ----------------
  // resp_d: cycles after ISSUE at which memory pulses (out of window = none).
  task automatic do_op(input logic [31:0] pc, input logic [31:0] addr, input logic [5:0] rg,
                       input logic [3:0] op, input logic [31:0] sdata, input int resp_d,
                       input logic [31:0] ld_data, input int stall, input bit noise,
                       input bit hold_next);
    bit is_ld, is_st, ok, err;
    int done_off;
    logic [31:0] exp_data;
    logic [REC_W-1:0] rec;

    // Reference model: when the completion appears and what it carries.
    is_ld = (op == 4'd7) || (op == 4'd8);
    is_st = (op == 4'd9) || (op == 4'd10);
    ok    = is_ld || is_st;
    if (!ok) begin
      err = 1'b1; done_off = 0;
    end else if (resp_d >= 1 && resp_d <= TIMEOUT - 1) begin
      err = 1'b0; done_off = resp_d + 1;
    end else begin
      err = 1'b1; done_off = TIMEOUT;
    end
    exp_data = (is_ld && !err) ? ld_data : 32'd0;
    exp_q.push_back({pc, rg, exp_data, is_st, err});

    // Offer the request.
    bus.req_pc     = pc;
    bus.req_addr   = addr;
    bus.req_reg    = rg;
    bus.req_optype = op;
    bus.req_data   = sdata;
    bus.req_valid  = 1'b1;
    bus.cmp_ready  = 1'b0;
    check_val("req_ready_idle", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;

    // In-flight cycles: k = cycles since ISSUE.
    for (int k = 0; k < done_off; k++) begin
      check_val("busy_cmp_valid", bus.cmp_valid, 0);
      check_val("busy_req_ready", bus.req_ready, 0);
      check_val("mem_optype", bus.mem_optype, (k == 0) ? op : 4'd0);
      check_val("mem_write_en", bus.mem_write_en, (k == 0) && is_st);
      check_val("mem_read_en", bus.mem_read_en, is_ld);
      check_val("mem_cache_miss", bus.mem_cache_miss, is_ld);
      check_val("mem_fields", {bus.mem_inst_pc, bus.mem_address, bus.mem_dataSw, bus.mem_reg},
                {pc, addr, sdata, rg});
      bus.mem_ld_valid = 1'b0;
      bus.mem_st_done  = 1'b0;
      bus.mem_ld_data  = $urandom;
      if (k == resp_d) begin
        if (is_ld) begin
          bus.mem_ld_valid = 1'b1;
          bus.mem_ld_data  = ld_data;
        end else begin
          bus.mem_st_done = 1'b1;
        end
      end else if (noise && $urandom_range(0, 3) == 0) begin
        // Right-kind pulse during ISSUE, wrong-kind pulse during WAIT.
        if ((k == 0) == is_ld) bus.mem_ld_valid = 1'b1;
        else bus.mem_st_done = 1'b1;
      end
      step();
    end

    // Completion presented; hold with cmp_ready low for 'stall' cycles.
    rec = exp_q.pop_front();
    for (int s = 0; s <= stall; s++) begin
      check_val("cmp_valid", bus.cmp_valid, 1);
      check_val("cmp_pc", bus.cmp_pc, rec[71:40]);
      check_val("cmp_reg", bus.cmp_reg, rec[39:34]);
      check_val("cmp_data", bus.cmp_data, rec[33:2]);
      check_val("cmp_is_store", bus.cmp_is_store, rec[1]);
      check_val("cmp_err", bus.cmp_err, rec[0]);
      check_val("done_req_ready", bus.req_ready, 0);
      check_val("done_strobes", {bus.mem_read_en, bus.mem_write_en, bus.mem_optype}, 0);
      bus.mem_ld_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_st_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_ld_data  = $urandom;
      if (hold_next) begin
        bus.req_valid  = 1'b1;
        bus.req_optype = 4'd8;
        bus.req_pc     = $urandom;
      end
      bus.cmp_ready = (s == stall);
      step();
    end
    bus.cmp_ready    = 1'b0;
    bus.mem_ld_valid = 1'b0;
    bus.mem_st_done  = 1'b0;
    check_val("post_hs_req_ready", bus.req_ready, 1);
    check_val("post_hs_cmp_valid", bus.cmp_valid, 0);
    check_val("post_hs_state", dbg.state, ST_IDLE);
  endtask

  task automatic reset_mid_load();
    bus.req_pc     = 32'h200;
    bus.req_addr   = 32'd9;
    bus.req_reg    = 6'd33;
    bus.req_optype = 4'd8;
    bus.req_data   = 32'hAAAA5555;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_val("rst_pre_read_en", bus.mem_read_en, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_mid");
    bus.mem_ld_valid = 1'b1;
    bus.mem_ld_data  = 32'hCAFEF00D;
    step();
    bus.mem_ld_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("rst_late_cmp_valid", bus.cmp_valid, 0);
      check_val("rst_late_state", dbg.state, ST_IDLE);
      step();
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    int opsel, dsel, op, d;
    clear_inputs();
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("after_reset");
    check_val("after_reset_state", dbg.state, ST_IDLE);

    // LW addr 5 reg 12, data at ISSUE+11.
    do_op(32'h100, 32'd5, 6'd12, 4'd8, 32'd0, MEM_LAT, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    // SW addr 3 data 0x1234.
    do_op(32'h104, 32'd3, 6'd1, 4'd10, 32'h1234, MEM_LAT, 32'h0, 0, 1'b0, 1'b0);
    // Back-to-back: next request waiting while completion is stalled 5 cycles.
    do_op(32'h108, 32'd7, 6'd2, 4'd8, 32'd0, MEM_LAT, 32'h11223344, 5, 1'b1, 1'b1);
    do_op(32'h10C, 32'd8, 6'd3, 4'd9, 32'h5A, 4, 32'h0, 0, 1'b1, 1'b0);
    // LB with no response: timeout error.
    do_op(32'h110, 32'd9, 6'd4, 4'd7, 32'd0, -1, 32'h0, 1, 1'b1, 1'b0);
    // Response on the expiry cycle wins.
    do_op(32'h114, 32'd10, 6'd5, 4'd8, 32'd0, TIMEOUT - 1, 32'h0BADCAFE, 0, 1'b1, 1'b0);
    // Unsupported optype 3.
    do_op(32'h118, 32'd11, 6'd6, 4'd3, 32'hFF, MEM_LAT, 32'h0, 2, 1'b1, 1'b0);
    reset_mid_load();

    for (int i = 0; i < 40; i++) begin
      opsel = $urandom_range(0, 9);
      if (opsel == 0) begin
        op = $urandom_range(0, 11);
        if (op >= 7) op = op + 4;
      end else begin
        op = 7 + $urandom_range(0, 3);
      end
      dsel = $urandom_range(0, 7);
      case (dsel)
        0:       d = $urandom_range(TIMEOUT, TIMEOUT + 13);
        1:       d = TIMEOUT - 1;
        2:       d = 1;
        3:       d = MEM_LAT;
        default: d = $urandom_range(1, TIMEOUT - 2);
      endcase
      do_op($urandom, $urandom, 6'($urandom_range(0, 63)), 4'(op), $urandom, d, $urandom,
            $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
